// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------
// Shares the single line-wide Data Memory port between the instruction
// cache (port m0) and the data cache (port m1). One requester is granted at
// a time; the grant is held until memory acknowledges, the requester
// withdraws its enable, or the wait exceeds TIMEOUT cycles. Every grant is
// followed by one GAP cycle with mem_enable_o low, so memory always sees a
// falling enable between two transactions.
//
// Handshake (both requester ports and the memory port): a requester raises
// mN_enable_i with write/addr/data stable and holds all of them until it
// sees mN_ack_o. Memory answers with a single-cycle mem_ack_i; the arbiter
// forwards that pulse combinationally to the granted port only. Read data
// is broadcast to both ports, and each requester samples it only on its own
// ack.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-low reset
//   m0_* / m1_*             requester ports (enable, write, addr, data in,
//                           data out, ack)
//   mem_*                   Data Memory port (enable, write, addr, data out,
//                           data in, ack)
//   busy_o                  a grant is active (GRANT0 or GRANT1)
//   err_o                   sticky timeout flag, cleared only by reset
//   state_o                 current FSM state (IDLE=0 GRANT0=1 GRANT1=2 GAP=3)

module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [LINE_W-1:0] m0_data_i,
  output logic [LINE_W-1:0] m0_data_o,
  output logic              m0_ack_o,

  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [LINE_W-1:0] m1_data_i,
  output logic [LINE_W-1:0] m1_data_o,
  output logic              m1_ack_o,

  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,

  output logic              busy_o,
  output logic              err_o,
  output logic [1:0]        state_o
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    GAP    = 2'd3
  } state_e;

  state_e           state_q,      state_d;
  logic             last_grant_q, last_grant_d;  // port granted most recently
  logic [CNT_W-1:0] wait_cnt_q,   wait_cnt_d;
  logic             err_q,        err_d;

  // Enable of whichever port currently holds the grant (0 outside grants).
  logic             grant_enable;

  always_comb begin
    grant_enable = 1'b0;
    case (state_q)
      GRANT0:  grant_enable = m0_enable_i;
      GRANT1:  grant_enable = m1_enable_i;
      default: grant_enable = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;  // makes port 0 the first winner after reset
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
    end
  end

  // --------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (m0_enable_i && m1_enable_i) begin
          // Contention: the port that did not win last time goes now.
          if (last_grant_q) begin
            state_d      = GRANT0;
            last_grant_d = 1'b0;
          end else begin
            state_d      = GRANT1;
            last_grant_d = 1'b1;
          end
        end else if (m0_enable_i) begin
          state_d      = GRANT0;
          last_grant_d = 1'b0;
        end else if (m1_enable_i) begin
          state_d      = GRANT1;
          last_grant_d = 1'b1;
        end
      end

      GRANT0, GRANT1: begin
        if (!mem_ack_i) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
        // An ack wins over a simultaneous enable drop: it is still
        // forwarded, and both cases end the grant the same way.
        if (mem_ack_i) begin
          state_d = GAP;
        end else if (!grant_enable) begin
          state_d = GAP;
        end else if (wait_cnt_q == CNT_LAST) begin
          // Memory never answered: abandon the grant without an ack. The
          // requester stays stalled; err_q records the event.
          err_d   = 1'b1;
          state_d = GAP;
        end
      end

      GAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------
  // Datapath mux and ack routing. Everything is decoded from the current
  // state, so an asynchronous reset drops mem_enable_o and both acks at
  // once.
  // --------------------------------------------------------------------
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    m0_ack_o     = 1'b0;
    m1_ack_o     = 1'b0;

    case (state_q)
      GRANT0: begin
        mem_enable_o = m0_enable_i;
        mem_write_o  = m0_write_i;
        mem_addr_o   = m0_addr_i;
        mem_data_o   = m0_data_i;
        m0_ack_o     = mem_ack_i;
      end
      GRANT1: begin
        mem_enable_o = m1_enable_i;
        mem_write_o  = m1_write_i;
        mem_addr_o   = m1_addr_i;
        mem_data_o   = m1_data_i;
        m1_ack_o     = mem_ack_i;
      end
      default: begin
      end
    endcase
  end

  assign m0_data_o = mem_data_i;
  assign m1_data_o = mem_data_i;

  assign busy_o    = (state_q == GRANT0) || (state_q == GRANT1);
  assign err_o     = err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter. A behavioural memory answers the main instance
// after mem_lat enabled cycles; each acknowledged transaction is compared
// against the expected queue filled by the test sequence. A second instance
// with TIMEOUT=8 and a silent memory exercises the timeout path.

module tb_mem_arbiter;

  localparam int IT_W = 290;  // {port, write, addr[31:0], data[255:0]}

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_G0   = 2'd1;
  localparam logic [1:0] S_G1   = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- main instance signals ----------------
  logic         m0_enable_i, m0_write_i, m1_enable_i, m1_write_i;
  logic [31:0]  m0_addr_i, m1_addr_i, mem_addr_o;
  logic [255:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         m0_ack_o, m1_ack_o, mem_enable_o, mem_write_o, mem_ack_i;
  logic         busy_o, err_o;
  logic [1:0]   state_o;

  mem_arbiter #(.ADDR_W(32), .LINE_W(256), .TIMEOUT(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
    .m0_data_i(m0_data_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
    .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
    .m1_data_i(m1_data_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .busy_o(busy_o), .err_o(err_o), .state_o(state_o)
  );

  // ---------------- timeout instance signals ----------------
  logic         t_m0_enable_i;
  logic         t_m0_write_i = 1'b0;
  logic [31:0]  t_m0_addr_i  = 32'h0000_0100;
  logic [255:0] t_m0_data_i  = '0;
  logic         t_m1_enable_i = 1'b0;
  logic         t_m1_write_i  = 1'b0;
  logic [31:0]  t_m1_addr_i   = '0;
  logic [255:0] t_m1_data_i   = '0;
  logic [255:0] t_mem_data_i  = '0;
  logic         t_mem_ack_i   = 1'b0;
  logic [255:0] t_m0_data_o, t_m1_data_o, t_mem_data_o;
  logic [31:0]  t_mem_addr_o;
  logic         t_m0_ack_o, t_m1_ack_o, t_mem_enable_o, t_mem_write_o;
  logic         t_busy_o, t_err_o;
  logic [1:0]   t_state_o;

  mem_arbiter #(.ADDR_W(32), .LINE_W(256), .TIMEOUT(8)) dut_to (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_enable_i(t_m0_enable_i), .m0_write_i(t_m0_write_i), .m0_addr_i(t_m0_addr_i),
    .m0_data_i(t_m0_data_i), .m0_data_o(t_m0_data_o), .m0_ack_o(t_m0_ack_o),
    .m1_enable_i(t_m1_enable_i), .m1_write_i(t_m1_write_i), .m1_addr_i(t_m1_addr_i),
    .m1_data_i(t_m1_data_i), .m1_data_o(t_m1_data_o), .m1_ack_o(t_m1_ack_o),
    .mem_enable_o(t_mem_enable_o), .mem_write_o(t_mem_write_o), .mem_addr_o(t_mem_addr_o),
    .mem_data_o(t_mem_data_o), .mem_data_i(t_mem_data_i), .mem_ack_i(t_mem_ack_i),
    .busy_o(t_busy_o), .err_o(t_err_o), .state_o(t_state_o)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [IT_W-1:0] got,
                       input logic [IT_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IT_W-1:0] item(input logic p, input logic wr,
                                           input logic [31:0] a,
                                           input logic [255:0] d);
    return {p, wr, a, d};
  endfunction

  logic [IT_W-1:0] exp_q[$];

  // ---------------- memory model + scoreboard ----------------
  logic [255:0] store [logic [31:0]];
  int mem_lat = 3;
  int ack_cnt [2];
  int low_run = 0;
  int last_gap = 0;

  function automatic logic [255:0] mem_read(input logic [31:0] a);
    if (store.exists(a)) return store[a];
    return {8{a}};
  endfunction

  initial begin : mem_model
    int cnt;
    logic wr;
    logic [31:0] a;
    logic [255:0] wd, rd;
    logic [IT_W-1:0] e;
    cnt = 0;
    ack_cnt[0] = 0;
    ack_cnt[1] = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (mem_enable_o) begin
        if (low_run > 0) last_gap = low_run;
        low_run = 0;
      end else begin
        low_run++;
      end
      if (!rst_i || !mem_enable_o) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt >= mem_lat) begin
          cnt = 0;
          wr  = mem_write_o;
          a   = mem_addr_o;
          wd  = mem_data_o;
          rd  = wr ? 256'h0 : mem_read(a);
          if (wr) store[a] = wd;
          mem_data_i = rd;
          mem_ack_i  = 1'b1;
          #1;
          if (exp_q.size() == 0) begin
            check("sb_unexpected_ack", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("ack_route", {m1_ack_o, m0_ack_o}, e[IT_W-1] ? 2'b10 : 2'b01);
            check("sb_txn", {m1_ack_o, wr, a, wr ? wd : (m1_ack_o ? m1_data_o : m0_data_o)}, e);
          end
          if (m1_ack_o) ack_cnt[1]++;
          else if (m0_ack_o) ack_cnt[0]++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_port(input int p, input logic en, input logic wr,
                          input logic [31:0] a, input logic [255:0] d);
    if (p == 0) begin
      m0_enable_i = en; m0_write_i = wr; m0_addr_i = a; m0_data_i = d;
    end else begin
      m1_enable_i = en; m1_write_i = wr; m1_addr_i = a; m1_data_i = d;
    end
  endtask

  // Raise a request and hold it until the port's ack is seen; optionally
  // drop the enable inside the ack cycle.
  task automatic do_req(input int p, input logic wr, input logic [31:0] a,
                        input logic [255:0] d, input bit drop);
    int start;
    bit got;
    start = ack_cnt[p];
    got   = 1'b0;
    set_port(p, 1'b1, wr, a, d);
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk_i);
      #2;
      if (ack_cnt[p] != start) got = 1'b1;
    end
    check($sformatf("ack_wait_p%0d", p), got, 1'b1);
    if (drop) set_port(p, 1'b0, 1'b0, 32'h0, 256'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  localparam logic [255:0] A5 = {32{8'hA5}};
  localparam logic [255:0] D1 = {8{32'h1111_2222}};
  localparam logic [255:0] D2 = {8{32'hC0DE_0C00}};
  localparam logic [255:0] D3 = {8{32'h3333_0240}};

  initial begin : main
    int a0, a1;
    bool_dummy: begin end
    set_port(0, 1'b0, 1'b0, 32'h0, 256'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 256'h0);
    t_m0_enable_i = 1'b0;
    store[32'h0000_0400] = A5;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_state", state_o, S_IDLE);
    check("rst_mem_en", mem_enable_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_acks", {m1_ack_o, m0_ack_o}, 2'b00);
    check("rst_mem_wr_addr", {mem_write_o, mem_addr_o}, 33'h0);
    #2 rst_i = 1'b1;
    idle(2);

    // Simultaneous requests after reset: m0 first, then m1 write
    exp_q.push_back(item(1'b0, 1'b0, 32'h0000_0100, {8{32'h0000_0100}}));
    exp_q.push_back(item(1'b1, 1'b1, 32'h0000_0200, D1));
    fork
      do_req(0, 1'b0, 32'h0000_0100, 256'h0, 1'b1);
      do_req(1, 1'b1, 32'h0000_0200, D1, 1'b1);
    join

    // Single read with latency 10
    idle(3);
    mem_lat = 10;
    a0 = ack_cnt[0];
    a1 = ack_cnt[1];
    exp_q.push_back(item(1'b1, 1'b0, 32'h0000_0400, A5));
    set_port(1, 1'b1, 1'b0, 32'h0000_0400, 256'h0);
    @(negedge clk_i);
    check("t1_cycle_t_en", mem_enable_o, 1'b0);
    check("t1_cycle_t_state", state_o, S_IDLE);
    @(negedge clk_i);
    check("t1_cycle_t1_en", mem_enable_o, 1'b1);
    check("t1_cycle_t1_state", state_o, S_G1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      #2;
      if (ack_cnt[1] != a1) break;
      check("t1_en_hold", mem_enable_o, 1'b1);
    end
    set_port(1, 1'b0, 1'b0, 32'h0, 256'h0);
    check("t1_m1_acks", ack_cnt[1] - a1, 1);
    @(negedge clk_i);
    check("t1_gap_en", mem_enable_o, 1'b0);
    check("t1_gap_state", state_o, S_GAP);
    @(negedge clk_i);
    check("t1_idle_state", state_o, S_IDLE);
    check("t1_m0_no_ack", ack_cnt[0] - a0, 0);

    // Writeback then refill on m1, refill raised inside the ack cycle
    mem_lat = 3;
    idle(2);
    a0 = ack_cnt[0];
    exp_q.push_back(item(1'b1, 1'b1, 32'h0000_0C00, D2));
    exp_q.push_back(item(1'b1, 1'b0, 32'h0000_0400, A5));
    do_req(1, 1'b1, 32'h0000_0C00, D2, 1'b0);
    do_req(1, 1'b0, 32'h0000_0400, 256'h0, 1'b1);
    check("t4_gap_ge2", last_gap >= 2, 1'b1);
    check("t4_m0_no_ack", ack_cnt[0] - a0, 0);

    // Round-robin with both ports held requesting
    idle(3);
    exp_q.push_back(item(1'b0, 1'b0, 32'h0000_0140, {8{32'h0000_0140}}));
    exp_q.push_back(item(1'b1, 1'b1, 32'h0000_0240, D3));
    exp_q.push_back(item(1'b0, 1'b0, 32'h0000_0180, {8{32'h0000_0180}}));
    exp_q.push_back(item(1'b1, 1'b0, 32'h0000_0240, D3));
    fork
      begin
        do_req(0, 1'b0, 32'h0000_0140, 256'h0, 1'b0);
        do_req(0, 1'b0, 32'h0000_0180, 256'h0, 1'b1);
      end
      begin
        do_req(1, 1'b1, 32'h0000_0240, D3, 1'b0);
        do_req(1, 1'b0, 32'h0000_0240, 256'h0, 1'b1);
      end
    join

    // Timeout on the TIMEOUT=8 instance, memory never answers
    idle(2);
    t_m0_enable_i = 1'b1;
    @(negedge clk_i);
    check("t5_idle", t_state_o, S_IDLE);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      check($sformatf("t5_grant_%0d", i), {t_state_o, t_err_o, t_m0_ack_o}, {S_G0, 2'b00});
    end
    @(negedge clk_i);
    check("t5_err_gap", {t_state_o, t_err_o, t_m0_ack_o}, {S_GAP, 2'b10});
    @(negedge clk_i);
    check("t5_back_idle", {t_state_o, t_err_o, t_m0_ack_o}, {S_IDLE, 2'b10});
    t_m0_enable_i = 1'b0;
    @(negedge clk_i);
    check("t5_err_sticky", t_err_o, 1'b1);

    // Reset three cycles into GRANT1
    idle(2);
    mem_lat = 30;
    set_port(1, 1'b1, 1'b0, 32'h0000_0800, 256'h0);
    @(negedge clk_i);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("t6_in_grant1", state_o, S_G1);
    end
    #2 rst_i = 1'b0;
    #1;
    check("t6_async_en", mem_enable_o, 1'b0);
    check("t6_async_busy", busy_o, 1'b0);
    check("t6_async_err", err_o, 1'b0);
    check("t6_async_state", state_o, S_IDLE);
    check("t6_async_ack", m1_ack_o, 1'b0);
    check("t6_to_err_cleared", t_err_o, 1'b0);
    set_port(1, 1'b0, 1'b0, 32'h0, 256'h0);
    repeat (3) @(posedge clk_i);
    #2 rst_i = 1'b1;
    a0 = ack_cnt[0];
    a1 = ack_cnt[1];
    idle(5);
    check("t6_no_late_ack", (ack_cnt[0] - a0) + (ack_cnt[1] - a1), 0);
    mem_lat = 3;
    exp_q.push_back(item(1'b0, 1'b0, 32'h0000_0500, {8{32'h0000_0500}}));
    exp_q.push_back(item(1'b1, 1'b0, 32'h0000_0600, {8{32'h0000_0600}}));
    fork
      do_req(0, 1'b0, 32'h0000_0500, 256'h0, 1'b1);
      do_req(1, 1'b0, 32'h0000_0600, 256'h0, 1'b1);
    join

    idle(4);
    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter sharing the single 256-bit Data Memory port between the instruction cache (port m0) and the data cache (port m1).
- Each requester issues line-sized read or write transactions with the enable/ack handshake it already uses.
- The arbiter grants one requester at a time, holds the grant until memory acknowledges, uses round-robin priority, and flags a sticky error if memory never acknowledges.

Parameters:
- ADDR_W, 32, address width.
- LINE_W, 256, line data width.
- TIMEOUT, 64, max cycles in a grant state without mem_ack_i before abort; counter width is clog2(TIMEOUT)+1.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-low reset.
- m0_enable_i  in  1  request from port 0 (icache), held high until m0_ack_o.
- m0_write_i  in  1  1 = write, 0 = read.
- m0_addr_i  in  ADDR_W  line address.
- m0_data_i  in  LINE_W  write data.
- m0_data_o  out  LINE_W  read data; carries mem_data_i.
- m0_ack_o  out  1  completion pulse to port 0.
- m1_enable_i, m1_write_i, m1_addr_i, m1_data_i, m1_data_o, m1_ack_o  same as m0, for port 1 (dcache).
- mem_enable_o  out  1  to Data Memory.
- mem_write_o  out  1  to Data Memory.
- mem_addr_o  out  ADDR_W  to Data Memory.
- mem_data_o  out  LINE_W  to Data Memory.
- mem_data_i  in  LINE_W  from Data Memory.
- mem_ack_i  in  1  from Data Memory; single-cycle pulse.
- busy_o  out  1  state is GRANT0 or GRANT1.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state=IDLE, last_grant=1 (port 0 wins first), wait_cnt=0, err_o=0.
  - All mem_* outputs, acks and busy_o are 0.
- States: IDLE, GRANT0, GRANT1, GAP.
- IDLE:
  - If only mN_enable_i is high, go to GRANTN.
  - If both are high, grant the port not equal to last_grant.
  - Set last_grant on entry to a grant state.
  - Clear wait_cnt.
  - mem_enable_o=0.
- GRANTN:
  - mem_enable_o = mN_enable_i.
  - mem_write_o, mem_addr_o and mem_data_o are muxed combinationally from port N.
  - Latency: request seen in IDLE at cycle t gives mem_enable_o high at t+1.
- Acknowledge:
  - mN_ack_o = mem_ack_i while in GRANTN, else 0.
  - The ack of the non-granted port is always 0.
  - m0_data_o = m1_data_o = mem_data_i; a requester only samples on its own ack.
- Leaving GRANTN:
  - On mem_ack_i, go to GAP.
  - If mN_enable_i drops before ack (abort), go to GAP; memory sees enable low.
  - If mem_ack_i and the enable drop occur in the same cycle, forward the ack and go to GAP.
- GAP:
  - One cycle with mem_enable_o=0 so memory observes the end of the transaction, then IDLE.
  - A back-to-back dcache writeback followed by refill therefore becomes two transactions separated by at least two idle cycles, IDLE included.
  - Under round-robin, the icache can be serviced between those two transactions.
- Timeout:
  - wait_cnt increments each cycle in GRANTN without mem_ack_i.
  - When wait_cnt reaches TIMEOUT-1, set err_o and go to GAP; no ack is given.
  - The requester stays stalled; err_o is for debug and bench checks.
  - err_o clears only on reset.
- Address and data from the granted port are passed through unregistered. The requester must hold them stable while its enable is high.
- Reset mid-transaction: the arbiter returns immediately to the reset values. Any memory transaction in flight is abandoned, and no ack is forwarded after reset.
- The ungranted port's inputs never reach mem_*; its enable simply waits.

Test Plan:
1. Single read:
   - Stimulus: m1 read, addr 0x0000_0400; memory acks after 10 cycles with data 0xA5..A5.
   - Required: m1_ack_o pulses once with m1_data_o=0xA5..A5; m0_ack_o stays 0; mem_enable_o high from t+1 to the ack cycle, then low in GAP.
2. Simultaneous requests after reset:
   - Stimulus: m0 read 0x100 and m1 write 0x200 raised together.
   - Required: m0 is granted first. After its ack, GAP, then IDLE; m1 is then granted with mem_write_o=1 and mem_addr_o=0x200.
3. Round-robin fairness:
   - Stimulus: both ports held requesting for 4 transactions.
   - Required: grant order is m0, m1, m0, m1; neither port waits more than one transaction.
4. Writeback then refill:
   - Stimulus: m1 write 0x0000_0C00, then a read of 0x0000_0400 asserted in the ack cycle; m0 idle.
   - Required: two separate transactions; mem_enable_o is low for at least 2 cycles between them; both acks delivered to m1.
5. Timeout:
   - Stimulus: TIMEOUT=8, m0 request, mem_ack_i never asserted.
   - Required: err_o rises after 8 grant cycles; state passes through GAP to IDLE; m0_ack_o is never asserted.
6. Reset mid-grant:
   - Stimulus: rst_i low 3 cycles into GRANT1.
   - Required: mem_enable_o and busy_o go to 0 asynchronously, err_o=0. After release, m0 wins a simultaneous request (last_grant=1).
